// File: rtl/ray_leaf_prim_issuer_pkg.sv
// Shared fixed-point and ray/primitive/hit payload types for the leaf primitive issuer.
package ray_leaf_prim_issuer_pkg;

  localparam int unsigned FIXED_W = 32;
  localparam int unsigned VI_W    = 32;

  // Q16.16 signed fixed point
  typedef logic signed [FIXED_W-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = fixed_t'(32'h7FFF_FFFF);

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef struct packed {
    vec3_t Origin;
    vec3_t Dir;
  } ray_t;

  typedef struct packed {
    vec3_t Min;
    vec3_t Max;
  } aabb_t;

  typedef struct packed {
    aabb_t           Aabb;
    logic [VI_W-1:0] VI;
  } bvh_prim_aabb_t;

  typedef struct packed {
    logic            bHit;
    fixed_t          T;
    logic [VI_W-1:0] VI;
  } hit_data_t;

  function automatic fixed_t fixed_inf();
    return FIXED_MAX;
  endfunction

  // Inverted box: can never be hit by any ray
  function automatic bvh_prim_aabb_t null_prim();
    bvh_prim_aabb_t p;
    p          = '0;
    p.Aabb.Min = '{x: FIXED_MAX, y: FIXED_MAX, z: FIXED_MAX};
    p.Aabb.Max = '{x: -FIXED_MAX, y: -FIXED_MAX, z: -FIXED_MAX};
    return p;
  endfunction

  function automatic hit_data_t no_hit();
    hit_data_t h;
    h      = '0;
    h.bHit = 1'b0;
    h.T    = fixed_inf();
    return h;
  endfunction

endpackage

// File: rtl/ray_leaf_prim_issuer_if.sv
// Bundle of request, primitive RAM, tester and response signals around the leaf issuer.
interface ray_leaf_prim_issuer_if #(
  parameter int unsigned UNIT_SIZE   = 4,
  parameter int unsigned PRIM_ADDR_W = 16,
  parameter int unsigned CNT_W       = 8
);
  import ray_leaf_prim_issuer_pkg::*;

  logic                                 req_valid;
  logic                                 req_ready;
  ray_t                                 req_ray;
  logic [PRIM_ADDR_W-1:0]               req_first;
  logic [CNT_W-1:0]                     req_count;
  logic                                 req_any_hit;

  logic                                 mem_rd_en;
  logic [PRIM_ADDR_W-1:0]               mem_rd_addr;
  bvh_prim_aabb_t                       mem_rd_data;

  ray_t                                 test_ray;
  bvh_prim_aabb_t [UNIT_SIZE-1:0]       test_prims;
  hit_data_t                            test_hit;

  logic                                 resp_valid;
  logic                                 resp_ready;
  hit_data_t                            resp_hit;

  // Issuer side
  modport master (
    input  req_valid, req_ray, req_first, req_count, req_any_hit,
    output req_ready,
    output mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output test_ray, test_prims,
    input  test_hit,
    output resp_valid, resp_hit,
    input  resp_ready
  );

  // Environment side: traversal engine, primitive RAM and tester
  modport slave (
    output req_valid, req_ray, req_first, req_count, req_any_hit,
    input  req_ready,
    input  mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  test_ray, test_prims,
    output test_hit,
    input  resp_valid, resp_hit,
    output resp_ready
  );

endinterface

// File: rtl/ray_leaf_prim_issuer.sv
// Leaf primitive issuer: streams a BVH leaf's primitives from RAM in batches of
// UNIT_SIZE into the combinational ray/primitive tester and folds the results into
// one closest hit per leaf request.
// Optional feature macro: RAY_ANYHIT_EARLY_EXIT_EN (any-hit queries stop at first hit).
module ray_leaf_prim_issuer #(
  parameter int unsigned UNIT_SIZE   = 4,
  parameter int unsigned PRIM_ADDR_W = 16,
  parameter int unsigned CNT_W       = 8
) (
  input logic                  clk,
  input logic                  reset,
  ray_leaf_prim_issuer_if.master bus
);
  import ray_leaf_prim_issuer_pkg::*;

  localparam int unsigned K_W   = $clog2(UNIT_SIZE + 1);
  localparam int unsigned IDX_W = (UNIT_SIZE > 1) ? $clog2(UNIT_SIZE) : 1;
  localparam bvh_prim_aabb_t [UNIT_SIZE-1:0] NULL_BATCH = {UNIT_SIZE{null_prim()}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_TEST,
    S_DONE
  } state_e;

  state_e                         state_q, state_d;
  ray_t                           ray_q, ray_d;
  logic [PRIM_ADDR_W-1:0]         addr_q, addr_d;
  logic                           rd_en_q, rd_en_d;
  logic [IDX_W-1:0]               rd_idx_q, rd_idx_d;
  logic [K_W-1:0]                 batch_k_q, batch_k_d;
  logic [CNT_W-1:0]               remaining_q, remaining_d;
  hit_data_t                      best_q, best_d;
  logic                           pend_q, pend_d;
  logic [IDX_W-1:0]               pend_slot_q, pend_slot_d;
  bvh_prim_aabb_t [UNIT_SIZE-1:0] prims_q, prims_d;
  logic                           req_ready_q, req_ready_d;
  logic                           resp_valid_q, resp_valid_d;
  hit_data_t                      resp_hit_q, resp_hit_d;

  logic                           start_batch;
  logic [CNT_W-1:0]               start_rem;
  logic [CNT_W-1:0]               rem_after;
  logic                           better;
  logic                           last_read;
  logic                           early_exit;

`ifdef RAY_ANYHIT_EARLY_EXIT_EN
  logic any_hit_q, any_hit_d;
`else
  logic unused_any_hit;
  assign unused_any_hit = bus.req_any_hit;
`endif

  function automatic logic [K_W-1:0] batch_size(input logic [CNT_W-1:0] rem);
    if (rem >= CNT_W'(UNIT_SIZE)) return K_W'(UNIT_SIZE);
    else                          return K_W'(rem);
  endfunction

  assign rem_after = remaining_q - CNT_W'(batch_k_q);
  assign last_read = (K_W'(rd_idx_q) + K_W'(1)) == batch_k_q;
  // Strict compare keeps the earlier batch on equal T
  assign better    = bus.test_hit.bHit && (!best_q.bHit || (bus.test_hit.T < best_q.T));

`ifdef RAY_ANYHIT_EARLY_EXIT_EN
  assign early_exit = any_hit_q && bus.test_hit.bHit;
`else
  assign early_exit = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    ray_d        = ray_q;
    addr_d       = addr_q;
    rd_en_d      = 1'b0;
    rd_idx_d     = rd_idx_q;
    batch_k_d    = batch_k_q;
    remaining_d  = remaining_q;
    best_d       = best_q;
    pend_d       = rd_en_q;
    pend_slot_d  = rd_idx_q;
    prims_d      = prims_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_hit_d   = resp_hit_q;
    start_batch  = 1'b0;
    start_rem    = remaining_q;
`ifdef RAY_ANYHIT_EARLY_EXIT_EN
    any_hit_d    = any_hit_q;
`endif

    // Read data lands one cycle after its strobe
    if (pend_q) prims_d[pend_slot_q] = bus.mem_rd_data;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          ray_d       = bus.req_ray;
          addr_d      = bus.req_first;
          remaining_d = bus.req_count;
          best_d      = no_hit();
          req_ready_d = 1'b0;
`ifdef RAY_ANYHIT_EARLY_EXIT_EN
          any_hit_d   = bus.req_any_hit;
`endif
          if (bus.req_count == '0) begin
            state_d = S_DONE;
          end else begin
            start_batch = 1'b1;
            start_rem   = bus.req_count;
          end
        end
      end
      S_FETCH: begin
        addr_d = addr_q + PRIM_ADDR_W'(1);
        if (last_read) begin
          state_d = S_WAIT;
        end else begin
          rd_en_d  = 1'b1;
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      S_WAIT: begin
        state_d = S_TEST;
      end
      S_TEST: begin
        if (better) best_d = bus.test_hit;
        remaining_d = rem_after;
        if (early_exit || (rem_after == '0)) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_hit_d   = best_d;
        end else begin
          start_batch = 1'b1;
          start_rem   = rem_after;
        end
      end
      S_DONE: begin
        resp_valid_d = 1'b1;
        resp_hit_d   = best_q;
        if (resp_valid_q && bus.resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // New batch: first read issues next cycle, unused slots become NULL
    if (start_batch) begin
      state_d   = S_FETCH;
      rd_en_d   = 1'b1;
      rd_idx_d  = '0;
      batch_k_d = batch_size(start_rem);
      prims_d   = NULL_BATCH;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ray_q        <= '0;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      rd_idx_q     <= '0;
      batch_k_q    <= '0;
      remaining_q  <= '0;
      best_q       <= no_hit();
      pend_q       <= 1'b0;
      pend_slot_q  <= '0;
      prims_q      <= NULL_BATCH;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= no_hit();
`ifdef RAY_ANYHIT_EARLY_EXIT_EN
      any_hit_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ray_q        <= ray_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      rd_idx_q     <= rd_idx_d;
      batch_k_q    <= batch_k_d;
      remaining_q  <= remaining_d;
      best_q       <= best_d;
      pend_q       <= pend_d;
      pend_slot_q  <= pend_slot_d;
      prims_q      <= prims_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
`ifdef RAY_ANYHIT_EARLY_EXIT_EN
      any_hit_q    <= any_hit_d;
`endif
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = addr_q;
  assign bus.test_ray    = ray_q;
  assign bus.test_prims  = prims_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;

endmodule

// File: tb/tb_ray_leaf_prim_issuer.sv
// Directed bench for ray_leaf_prim_issuer with a primitive RAM model, a behavioural
// closest-hit tester and a response scoreboard.
module tb_ray_leaf_prim_issuer;
  import ray_leaf_prim_issuer_pkg::*;

  localparam int unsigned UNIT_SIZE   = 4;
  localparam int unsigned PRIM_ADDR_W = 16;
  localparam int unsigned CNT_W       = 8;

  localparam fixed_t F_HALF = fixed_t'(32'h0000_8000);
  localparam fixed_t F1_5   = fixed_t'(32'h0001_8000);
  localparam fixed_t F2     = fixed_t'(32'h0002_0000);
  localparam fixed_t F3     = fixed_t'(32'h0003_0000);
  localparam fixed_t F4     = fixed_t'(32'h0004_0000);
  localparam fixed_t F5     = fixed_t'(32'h0005_0000);
  localparam fixed_t F6     = fixed_t'(32'h0006_0000);
  localparam fixed_t F7     = fixed_t'(32'h0007_0000);

  typedef struct {
    hit_data_t hit;
    int        lat;
    int        reads;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  bvh_prim_aabb_t mem [256];
  hit_data_t tst;
  ray_t cur_ray;
  bvh_prim_aabb_t [UNIT_SIZE-1:0] null4;

  always #5 clk = ~clk;

  ray_leaf_prim_issuer_if #(
    .UNIT_SIZE(UNIT_SIZE), .PRIM_ADDR_W(PRIM_ADDR_W), .CNT_W(CNT_W)
  ) bus ();

  ray_leaf_prim_issuer #(
    .UNIT_SIZE(UNIT_SIZE), .PRIM_ADDR_W(PRIM_ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Primitive RAM, one-cycle read latency, low 8 address bits decoded
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr[7:0]];
  end

  // Tester: a box with Min.x <= Max.x is hit at T = Min.y; earliest slot wins ties
  always_comb begin
    tst = no_hit();
    for (int i = 0; i < int'(UNIT_SIZE); i++) begin
      if ((bus.test_prims[i].Aabb.Min.x <= bus.test_prims[i].Aabb.Max.x) &&
          (!tst.bHit || (bus.test_prims[i].Aabb.Min.y < tst.T))) begin
        tst.bHit = 1'b1;
        tst.T    = bus.test_prims[i].Aabb.Min.y;
        tst.VI   = bus.test_prims[i].VI;
      end
    end
  end
  assign bus.test_hit = tst;

  function automatic bvh_prim_aabb_t mk_miss(input int vi);
    bvh_prim_aabb_t p;
    p = '0;
    p.Aabb.Min.x = fixed_t'(32'h0001_0000);
    p.Aabb.Max.x = '0;
    p.VI = 32'(vi);
    return p;
  endfunction

  function automatic bvh_prim_aabb_t mk_hit(input fixed_t t, input int vi);
    bvh_prim_aabb_t p;
    p = '0;
    p.Aabb.Min.y = t;
    p.VI = 32'(vi);
    return p;
  endfunction

  function automatic hit_data_t mk_exp(input logic b, input fixed_t t, input int vi);
    hit_data_t h;
    h.bHit = b;
    h.T    = t;
    h.VI   = 32'(vi);
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one leaf, follow it to its response and check it against the scoreboard
  task automatic run_leaf(input logic [15:0] first, input logic [7:0] count, input logic any,
                          input hit_data_t exp_hit, input int exp_lat, input int exp_reads,
                          input int stall);
    exp_t e;
    int   lat;
    int   nreads;
    logic got;
    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    cur_ray = ray_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    bus.req_valid   = 1'b1;
    bus.req_ray     = cur_ray;
    bus.req_first   = first;
    bus.req_count   = count;
    bus.req_any_hit = any;
    bus.resp_ready  = (stall == 0);
    sb.push_back('{hit: exp_hit, lat: exp_lat, reads: exp_reads});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat    = 0;
    nreads = 0;
    got    = 1'b0;
    while (!got && lat < 200) begin
      if (bus.mem_rd_en) begin
        chk("rd_addr", 64'(bus.mem_rd_addr), 64'(16'(first + 16'(nreads))));
        nreads++;
      end
      if (bus.resp_valid) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    chk("resp_timeout", 64'(got), 64'd1);
    if (got) begin
      e = sb.pop_front();
      chk("latency", 64'(lat), 64'(e.lat));
      chk("read_count", 64'(nreads), 64'(e.reads));
      chk("resp_bHit", 64'(bus.resp_hit.bHit), 64'(e.hit.bHit));
      chk("resp_T", 64'(bus.resp_hit.T), 64'(e.hit.T));
      chk("resp_VI", 64'(bus.resp_hit.VI), 64'(e.hit.VI));
      chk("test_ray", 64'(bus.test_ray === cur_ray), 64'd1);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        #1;
        chk("stall_valid", 64'(bus.resp_valid), 64'd1);
        chk("stall_T", 64'(bus.resp_hit.T), 64'(e.hit.T));
        chk("stall_no_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("resp_drop", 64'(bus.resp_valid), 64'd0);
      chk("req_ready_back", 64'(bus.req_ready), 64'd1);
    end
  endtask

  initial begin
    int seen;
    null4 = {UNIT_SIZE{null_prim()}};
    for (int i = 0; i < 256; i++) mem[i] = mk_miss(i);
    mem[8'h12] = mk_hit(F3, 'h12);
    mem[8'h21] = mk_hit(F5, 'h21);
    mem[8'h25] = mk_hit(F2, 'h25);
    mem[8'h31] = mk_hit(F4, 'h31);
    mem[8'h36] = mk_hit(F4, 'h36);
    mem[8'h41] = mk_hit(F6, 'h41);
    mem[8'h49] = mk_hit(F1_5, 'h49);
    mem[8'h60] = mk_hit(F7, 'h60);
    mem[8'h00] = mk_hit(F_HALF, 'h1000);

    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_ray     = '0;
    bus.req_first   = '0;
    bus.req_count   = '0;
    bus.req_any_hit = 1'b0;
    bus.resp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_bHit", 64'(bus.resp_hit.bHit), 64'd0);
    chk("rst_resp_T", 64'(bus.resp_hit.T), 64'(fixed_inf()));
    chk("rst_prims_null", 64'(bus.test_prims === null4), 64'd1);

    // Empty leaf
    run_leaf(16'h0010, 8'd0, 1'b0, mk_exp(1'b0, fixed_inf(), 0), 1, 0, 0);
    // One full batch, hit in slot 2
    run_leaf(16'h0010, 8'd4, 1'b0, mk_exp(1'b1, F3, 'h12), 6, 4, 0);
    // Two batches, second partially NULL, closer hit in batch 1
    run_leaf(16'h0020, 8'd6, 1'b0, mk_exp(1'b1, F2, 'h25), 10, 6, 0);
    chk("null_slot2", 64'(bus.test_prims[2] === null_prim()), 64'd1);
    chk("null_slot3", 64'(bus.test_prims[3] === null_prim()), 64'd1);
    chk("slot1_vi", 64'(bus.test_prims[1].VI), 64'h25);
    // Equal T across batches keeps the batch-0 primitive
    run_leaf(16'h0030, 8'd8, 1'b0, mk_exp(1'b1, F4, 'h31), 12, 8, 0);
    // Any-hit query
`ifdef RAY_ANYHIT_EARLY_EXIT_EN
    run_leaf(16'h0040, 8'd12, 1'b1, mk_exp(1'b1, F6, 'h41), 6, 4, 0);
`else
    run_leaf(16'h0040, 8'd12, 1'b1, mk_exp(1'b1, F1_5, 'h49), 18, 12, 0);
`endif

    // Reset in the middle of FETCH aborts the leaf
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_first   = 16'h0050;
    bus.req_count   = 8'd8;
    bus.req_any_hit = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midfetch_rd_en", 64'(bus.mem_rd_en), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
    chk("abort_rd_en", 64'(bus.mem_rd_en), 64'd0);
    chk("abort_resp_T", 64'(bus.resp_hit.T), 64'(fixed_inf()));
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.resp_valid || bus.mem_rd_en) seen++;
      @(posedge clk);
      #1;
    end
    chk("no_stale_activity", 64'(seen), 64'd0);
    // Single primitive leaf with a stalled consumer
    run_leaf(16'h0060, 8'd1, 1'b0, mk_exp(1'b1, F7, 'h60), 3, 1, 3);
    // Address wraps past the top of the primitive space
    run_leaf(16'hFFFE, 8'd3, 1'b0, mk_exp(1'b1, F_HALF, 'h1000), 5, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
